// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one 24-bit I2C write engine among
// NUM_REQ requesters, with NACK retry and a watchdog on the WAIT phase.
module i2c_cmd_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [24*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      err,
  output logic                    busy,
  output logic                    eng_start,
  output logic [23:0]             eng_data,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  input  logic                    eng_nack
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CMD_W = 24;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_served;
  logic [IDX_W-1:0]   gnt_idx;
  logic [3:0]         retry_cnt;
  logic [15:0]        timer;
  logic               resp_err;

  logic [CMD_W-1:0]   cmd_c [NUM_REQ];
  logic               win_found_c;
  logic [IDX_W-1:0]   win_idx_c;

  // Unpack the flat command bus into one slice per requester
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cmd_c[i] = req_data[CMD_W*i +: CMD_W];
    end
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    // Walk from farthest to nearest so the nearest requesting index wins
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      if (req[IDX_W'((int'(last_served) + k) % int'(NUM_REQ))]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'((int'(last_served) + k) % int'(NUM_REQ));
      end
    end
  end

  // Arbitration / issue / wait / response sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      ack         <= '0;
      err         <= '0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
      eng_data    <= '0;
      last_served <= IDX_W'(NUM_REQ - 1);
      gnt_idx     <= '0;
      retry_cnt   <= '0;
      timer       <= '0;
      resp_err    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      ack       <= '0;
      err       <= '0;
      case (state)
        IDLE: begin
          // Skip the cycle carrying ack/err so the requester can drop req
          if (win_found_c && (ack == '0) && (err == '0)) begin
            grant            <= '0;
            grant[win_idx_c] <= 1'b1;
            gnt_idx          <= win_idx_c;
            eng_data         <= cmd_c[win_idx_c];
            retry_cnt        <= '0;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!eng_busy) begin
            eng_start <= 1'b1;
            timer     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 16'd1;
          if (eng_done) begin
            if (!eng_nack) begin
              resp_err <= 1'b0;
              state    <= RESP;
            end else if (retry_cnt < 4'(RETRY_MAX)) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= ISSUE;
            end else begin
              resp_err <= 1'b1;
              state    <= RESP;
            end
          end else if (timer + 16'd1 == 16'(TIMEOUT)) begin
            resp_err <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (resp_err) err <= grant;
          else          ack <= grant;
          last_served <= gnt_idx;
          grant       <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: behavioural engine, event monitor and
// scenario tasks checked against a spec-level arbitration model.
module tb_i2c_cmd_arbiter;

  localparam int RMAX = 3;
  localparam int TOUT = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [47:0] req_data = '0;
  logic [1:0]  grant, ack, err;
  logic        busy, eng_start;
  logic [23:0] eng_data;
  logic        eng_busy = 1'b0, eng_done = 1'b0, eng_nack = 1'b0;

  i2c_cmd_arbiter #(.NUM_REQ(2), .RETRY_MAX(RMAX), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .busy(busy),
    .eng_start(eng_start), .eng_data(eng_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model controls and observations
  int eng_lat = 20;
  bit eng_hang = 0;
  bit nack_q[$];
  int done_q[$];
  int start_cnt = 0, ack_cnt = 0, err_cnt = 0, both_cnt = 0;
  int start_cyc_q[$];
  logic [23:0] start_data_q[$];
  int ack_cyc = 0, err_cyc = 0;
  logic [1:0] last_ack = '0, last_err = '0;
  int last_m = 1;

  // Behavioural I2C engine: busy from start, done after eng_lat cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (eng_start && !eng_hang) begin
        eng_busy = 1'b1;
        repeat (eng_lat) @(posedge clk);
        #1;
        eng_done = 1'b1;
        eng_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        done_q.push_back(cyc + 1);
        @(posedge clk); #1;
        eng_done = 1'b0;
        eng_nack = 1'b0;
        eng_busy = 1'b0;
      end
    end
  end

  // Event monitor, sampled shortly after each rising edge
  initial begin
    forever begin
      @(posedge clk); #2;
      if (eng_start) begin
        start_cnt++;
        start_cyc_q.push_back(cyc);
        start_data_q.push_back(eng_data);
      end
      if (ack != 0) begin ack_cnt++; ack_cyc = cyc; last_ack = ack; end
      if (err != 0) begin err_cnt++; err_cyc = cyc; last_err = err; end
      if (ack != 0 && err != 0) both_cnt++;
    end
  end

  // Spec-level round robin: first requester after last_served, wrapping
  function automatic int rr_pick(input logic [1:0] r, input int last);
    for (int k = 1; k <= 2; k++) begin
      if (r[(last + k) % 2]) return (last + k) % 2;
    end
    return -1;
  endfunction

  task automatic wait_grant(output bit to);
    to = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant != 0) begin to = 0; break; end
    end
  endtask

  task automatic wait_resp(output bit to);
    to = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ack != 0 || err != 0) begin to = 0; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got=%b exp=00", grant); end
    n_vec++; if (ack !== 2'b00 || err !== 2'b00) begin n_err++; $display("FAIL reset_resp ack=%b err=%b exp=00/00", ack, err); end
    n_vec++; if (busy !== 1'b0 || eng_start !== 1'b0) begin n_err++; $display("FAIL reset_ctl busy=%b start=%b exp=0/0", busy, eng_start); end
    n_vec++; if (eng_data !== 24'h0) begin n_err++; $display("FAIL reset_data got=%h exp=000000", eng_data); end
    reset = 1'b0;
    last_m = 1;
    @(negedge clk);
  endtask

  task automatic test_single;
    bit to;
    int s0 = start_cnt, e0 = err_cnt;
    eng_lat = 20;
    req_data = {24'h0, 24'h729803};
    req = 2'b01;
    @(negedge clk);
    n_vec++; if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant got=%b exp=01", grant); end
    n_vec++; if (eng_data !== 24'h729803 || busy !== 1'b1) begin n_err++; $display("FAIL single_data got=%h busy=%b exp=729803/1", eng_data, busy); end
    n_vec++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL single_start_early got=%b exp=0", eng_start); end
    @(negedge clk);
    n_vec++; if (eng_start !== 1'b1) begin n_err++; $display("FAIL single_start got=%b exp=1", eng_start); end
    wait_resp(to);
    req = 2'b00;
    n_vec++; if (to) begin n_err++; $display("FAIL single_timeout got=none exp=ack"); end
    n_vec++; if (ack !== 2'b01 || err !== 2'b00) begin n_err++; $display("FAIL single_ack ack=%b err=%b exp=01/00", ack, err); end
    n_vec++; if (ack_cyc !== done_q[$] + 1) begin n_err++; $display("FAIL single_ack_lat got=%0d exp=%0d", ack_cyc, done_q[$] + 1); end
    @(negedge clk);
    n_vec++; if (ack !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL single_pulse ack=%b grant=%b busy=%b exp=00/00/0", ack, grant, busy); end
    n_vec++; if (start_cnt - s0 !== 1 || err_cnt !== e0) begin n_err++; $display("FAIL single_counts starts=%0d errs=%0d exp=1/0", start_cnt - s0, err_cnt - e0); end
    last_m = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit to;
    int w, prev_ack_cyc;
    logic [23:0] d [2];
    eng_lat = $urandom_range(3, 12);
    d[0] = 24'($urandom); d[1] = 24'($urandom);
    req_data = {d[1], d[0]};
    req = 2'b11;
    prev_ack_cyc = -1;
    for (int t = 0; t < 4; t++) begin
      w = rr_pick(2'b11, last_m);
      wait_grant(to);
      n_vec++; if (to || grant !== 2'(1 << w)) begin n_err++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, grant, 2'(1 << w)); end
      n_vec++; if (eng_data !== d[w]) begin n_err++; $display("FAIL rr_data t=%0d got=%h exp=%h", t, eng_data, d[w]); end
      if (prev_ack_cyc >= 0) begin
        n_vec++; if (cyc !== prev_ack_cyc + 2) begin n_err++; $display("FAIL rr_regrant t=%0d got=%0d exp=%0d", t, cyc, prev_ack_cyc + 2); end
      end
      wait_resp(to);
      if (t == 3) req = 2'b00;
      n_vec++; if (to || ack !== 2'(1 << w)) begin n_err++; $display("FAIL rr_ack t=%0d got=%b exp=%b", t, ack, 2'(1 << w)); end
      prev_ack_cyc = cyc;
      last_m = w;
    end
    repeat (4) @(negedge clk);
    n_vec++; if (grant !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL rr_idle grant=%b busy=%b exp=00/0", grant, busy); end
  endtask

  task automatic test_nack_retry;
    bit to;
    int s0 = start_cnt, e0 = err_cnt;
    eng_lat = 5;
    nack_q = '{1'b1, 1'b1};
    done_q.delete(); start_cyc_q.delete();
    req_data = {24'h3c4d5e, 24'h112233};
    req = 2'b01;
    wait_resp(to);
    req = 2'b00;
    n_vec++; if (to || ack !== 2'b01) begin n_err++; $display("FAIL nack_ack got=%b exp=01", ack); end
    n_vec++; if (start_cnt - s0 !== 3 || err_cnt !== e0) begin n_err++; $display("FAIL nack_counts starts=%0d errs=%0d exp=3/0", start_cnt - s0, err_cnt - e0); end
    n_vec++; if (start_cyc_q.size() < 2 || done_q.size() < 1 || start_cyc_q[1] !== done_q[0] + 1) begin n_err++; $display("FAIL nack_restart_lat got=%0d exp=%0d", (start_cyc_q.size() > 1) ? start_cyc_q[1] : -1, (done_q.size() > 0) ? done_q[0] + 1 : -1); end
    last_m = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_retry_exhausted;
    bit to;
    int s0 = start_cnt, a0 = ack_cnt;
    eng_lat = 4;
    nack_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    req = 2'b01;
    wait_resp(to);
    req = 2'b00;
    n_vec++; if (to || err !== 2'b01) begin n_err++; $display("FAIL exh_err got=%b exp=01", err); end
    n_vec++; if (start_cnt - s0 !== RMAX + 1 || ack_cnt !== a0) begin n_err++; $display("FAIL exh_counts starts=%0d acks=%0d exp=%0d/0", start_cnt - s0, ack_cnt - a0, RMAX + 1); end
    nack_q.delete();
    last_m = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout;
    bit to;
    int a0 = ack_cnt;
    eng_hang = 1;
    start_cyc_q.delete();
    req = 2'b10;
    wait_resp(to);
    req = 2'b00;
    n_vec++; if (to || err !== 2'b10) begin n_err++; $display("FAIL tout_err got=%b exp=10", err); end
    n_vec++; if (start_cyc_q.size() != 1 || err_cyc !== start_cyc_q[0] + TOUT + 1) begin n_err++; $display("FAIL tout_lat got=%0d exp=%0d", err_cyc, (start_cyc_q.size() > 0) ? start_cyc_q[0] + TOUT + 1 : -1); end
    n_vec++; if (busy !== 1'b0 || grant !== 2'b00 || ack_cnt !== a0) begin n_err++; $display("FAIL tout_idle busy=%b grant=%b acks=%0d exp=0/00/0", busy, grant, ack_cnt - a0); end
    eng_hang = 0;
    last_m = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit to;
    int s0 = start_cnt, a0, e0;
    eng_lat = 25;
    req = 2'b01;
    for (int i = 0; i < 50 && start_cnt == s0; i++) @(negedge clk);
    req = 2'b00;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (grant !== 2'b00 || busy !== 1'b0 || eng_start !== 1'b0 || eng_data !== 24'h0) begin n_err++; $display("FAIL rmid_outs grant=%b busy=%b start=%b data=%h exp=all0", grant, busy, eng_start, eng_data); end
    a0 = ack_cnt; e0 = err_cnt;
    repeat (30) @(negedge clk);
    n_vec++; if (ack_cnt !== a0 || err_cnt !== e0 || eng_busy !== 1'b0) begin n_err++; $display("FAIL rmid_late acks=%0d errs=%0d eng_busy=%b exp=0/0/0", ack_cnt - a0, err_cnt - e0, eng_busy); end
    last_m = 1;
    eng_lat = 6;
    req = 2'b10;
    wait_grant(to);
    n_vec++; if (to || grant !== 2'b10) begin n_err++; $display("FAIL rmid_grant got=%b exp=10", grant); end
    wait_resp(to);
    req = 2'b00;
    n_vec++; if (to || ack !== 2'b10) begin n_err++; $display("FAIL rmid_ack got=%b exp=10", ack); end
    last_m = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    bit to;
    int w, n_nack, s0, n_starts;
    logic [1:0] pat;
    logic [23:0] d [2];
    for (int t = 0; t < 16; t++) begin
      pat = 2'($urandom_range(1, 3));
      d[0] = 24'($urandom); d[1] = 24'($urandom);
      n_nack = $urandom_range(0, 5);
      eng_lat = $urandom_range(1, 30);
      nack_q.delete();
      for (int i = 0; i < n_nack; i++) nack_q.push_back(1'b1);
      start_data_q.delete();
      s0 = start_cnt;
      w = rr_pick(pat, last_m);
      n_starts = ((n_nack < RMAX) ? n_nack : RMAX) + 1;
      req_data = {d[1], d[0]};
      req = pat;
      wait_grant(to);
      n_vec++; if (to || grant !== 2'(1 << w)) begin n_err++; $display("FAIL rand_grant t=%0d got=%b exp=%b", t, grant, 2'(1 << w)); end
      // requests dropped and commands scrambled once granted
      req = 2'b00;
      req_data = {24'($urandom), 24'($urandom)};
      wait_resp(to);
      if (n_nack > RMAX) begin
        n_vec++; if (to || err !== 2'(1 << w) || ack !== 2'b00) begin n_err++; $display("FAIL rand_err t=%0d err=%b ack=%b exp=%b/00", t, err, ack, 2'(1 << w)); end
      end else begin
        n_vec++; if (to || ack !== 2'(1 << w) || err !== 2'b00) begin n_err++; $display("FAIL rand_ack t=%0d ack=%b err=%b exp=%b/00", t, ack, err, 2'(1 << w)); end
      end
      @(negedge clk);
      n_vec++; if (start_cnt - s0 !== n_starts) begin n_err++; $display("FAIL rand_starts t=%0d got=%0d exp=%0d", t, start_cnt - s0, n_starts); end
      foreach (start_data_q[i]) begin
        n_vec++; if (start_data_q[i] !== d[w]) begin n_err++; $display("FAIL rand_data t=%0d i=%0d got=%h exp=%h", t, i, start_data_q[i], d[w]); end
      end
      last_m = w;
      repeat (2) @(negedge clk);
    end
    nack_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nack_retry();
    test_retry_exhausted();
    test_timeout();
    test_reset_mid();
    test_random();
    n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL ack_err_overlap got=%0d exp=0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
